tdc_measure_sequencer: RTL and testbench

- Controller that sequences one CoarseCounter channel through a full TDC measurement: arm, clear the counter, start on the first start-hit edge, stop on the stop-hit edge or on timeout, capture the count, then hold the result for readout.
- Sits between the discriminator/synchronizer outputs and the CoarseCounter in the clk_CC domain.
- Presents results to the readout FIFO through a valid/ready handshake.

---
 rtl/tdc_pkg.sv | 20 ++
 rtl/tdc_edge_detect.sv | 22 ++
 rtl/tdc_measure_sequencer.sv | 171 +++++++++++++++++
 tb/tb_tdc_measure_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC measurement sequencer.
package tdc_pkg;

   localparam int COUNT_W_DEFAULT = 12;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ARMED,
      RUNNING,
      WAITV,
      HOLD
   } state_t;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_COINC   = 2'b10;
   localparam logic [1:0] ST_NOVALID = 2'b11;

endpackage

// File: rtl/tdc_edge_detect.sv
// Registered rising-edge detector; history resets to 1 so a level that is
// already high when reset releases never counts as an edge.
module tdc_edge_detect (
   input  logic clk_CC,
   input  logic reset_CC,
   input  logic sig_in,
   output logic rise
);

   logic prev_q;
   logic prev_d;

   always_comb prev_d = sig_in;

   always_ff @(posedge clk_CC) begin
      if (!reset_CC) prev_q <= 1'b1;
      else           prev_q <= prev_d;
   end

   assign rise = sig_in & ~prev_q;

endmodule

// File: rtl/tdc_measure_sequencer.sv
// Sequences one CoarseCounter channel through arm/clear/start/stop/capture and
// hands the captured count to readout over a valid/ready handshake.
//
// state   | meaning
// IDLE    | counter held in clear, waiting for arm
// CLEAR   | one-cycle counter clear before arming
// ARMED   | waiting for a start edge
// RUNNING | counter running, waiting for stop edge or timeout
// WAITV   | stop issued, waiting for the counter's valid
// HOLD    | result presented until readout accepts it
module tdc_measure_sequencer
   import tdc_pkg::*;
#(
   parameter int COUNT_W     = COUNT_W_DEFAULT,
   parameter int TIMEOUT_CYC = 4000,
   parameter int VALID_WAIT  = 8
) (
   input  logic               clk_CC,
   input  logic               reset_CC,
   input  logic               arm,
   input  logic               hit_start,
   input  logic               hit_stop,
   input  logic               cc_valid,
   input  logic [COUNT_W-1:0] cc_count,
   output logic               cc_start,
   output logic               cc_stop,
   output logic               cc_reset,
   output logic [COUNT_W-1:0] res_count,
   output logic [1:0]         res_status,
   output logic               res_valid,
   input  logic               res_ready,
   output logic               busy
);

   localparam int                 WAIT_W    = $clog2(VALID_WAIT + 1);
   localparam logic [COUNT_W-1:0] TMO_LAST  = COUNT_W'(TIMEOUT_CYC - 1);
   localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(VALID_WAIT - 1);

   logic start_edge;
   logic stop_edge;

   tdc_edge_detect u_start_edge (
      .clk_CC   (clk_CC),
      .reset_CC (reset_CC),
      .sig_in   (hit_start),
      .rise     (start_edge)
   );

   tdc_edge_detect u_stop_edge (
      .clk_CC   (clk_CC),
      .reset_CC (reset_CC),
      .sig_in   (hit_stop),
      .rise     (stop_edge)
   );

   state_t             state_q, state_d;
   logic [COUNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic               tmo_flag_q, tmo_flag_d;
   logic               cc_start_q, cc_start_d;
   logic               cc_stop_q, cc_stop_d;
   logic               cc_reset_q, cc_reset_d;
   logic [COUNT_W-1:0] res_count_q, res_count_d;
   logic [1:0]         res_status_q, res_status_d;
   logic               res_valid_q, res_valid_d;
   logic               busy_q, busy_d;

   always_comb begin
      state_d      = state_q;
      tmo_cnt_d    = tmo_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      tmo_flag_d   = tmo_flag_q;
      cc_start_d   = 1'b0;
      cc_stop_d    = 1'b0;
      res_count_d  = res_count_q;
      res_status_d = res_status_q;

      case (state_q)
         IDLE: begin
            if (arm) state_d = CLEAR;
         end
         CLEAR: begin
            state_d = ARMED;
         end
         ARMED: begin
            if (start_edge && stop_edge) begin
               res_count_d  = '0;
               res_status_d = ST_COINC;
               state_d      = HOLD;
            end else if (start_edge) begin
               cc_start_d = 1'b1;
               tmo_cnt_d  = '0;
               tmo_flag_d = 1'b0;
               state_d    = RUNNING;
            end else if (!arm) begin
               state_d = IDLE;
            end
         end
         RUNNING: begin
            tmo_cnt_d = tmo_cnt_q + COUNT_W'(1);
            // A stop edge on the timeout cycle wins and reports a clean stop.
            if (stop_edge || (tmo_cnt_q == TMO_LAST)) begin
               cc_stop_d  = 1'b1;
               tmo_flag_d = !stop_edge;
               wait_cnt_d = '0;
               state_d    = WAITV;
            end
         end
         WAITV: begin
            if (cc_valid) begin
               res_count_d  = cc_count;
               res_status_d = tmo_flag_q ? ST_TIMEOUT : ST_OK;
               state_d      = HOLD;
            end else if (wait_cnt_q == WAIT_LAST) begin
               res_count_d  = '0;
               res_status_d = ST_NOVALID;
               state_d      = HOLD;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         HOLD: begin
            if (res_valid_q && res_ready) state_d = arm ? CLEAR : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      cc_reset_d  = (state_d == IDLE) || (state_d == CLEAR);
      busy_d      = (state_d != IDLE);
      res_valid_d = (state_d == HOLD);
   end

   always_ff @(posedge clk_CC) begin
      if (!reset_CC) begin
         state_q      <= IDLE;
         tmo_cnt_q    <= '0;
         wait_cnt_q   <= '0;
         tmo_flag_q   <= 1'b0;
         cc_start_q   <= 1'b0;
         cc_stop_q    <= 1'b0;
         cc_reset_q   <= 1'b1;
         res_count_q  <= '0;
         res_status_q <= ST_OK;
         res_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmo_cnt_q    <= tmo_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         tmo_flag_q   <= tmo_flag_d;
         cc_start_q   <= cc_start_d;
         cc_stop_q    <= cc_stop_d;
         cc_reset_q   <= cc_reset_d;
         res_count_q  <= res_count_d;
         res_status_q <= res_status_d;
         res_valid_q  <= res_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign cc_start   = cc_start_q;
   assign cc_stop    = cc_stop_q;
   assign cc_reset   = cc_reset_q;
   assign res_count  = res_count_q;
   assign res_status = res_status_q;
   assign res_valid  = res_valid_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_tdc_measure_sequencer.sv
// Scoreboard bench: stimulus pushes the expected result of each measurement,
// a monitor pops and compares at every result handshake.
module tb_tdc_measure_sequencer;
   import tdc_pkg::*;

   localparam int CW  = 12;
   localparam int TMO = 16;
   localparam int VW  = 8;
   localparam int PER = 30;
   localparam int K_COINC = 0;
   localparam int K_NORM  = 1;

   logic          clk_CC = 1'b0;
   logic          reset_CC, arm, hit_start, hit_stop, res_ready;
   logic          cc_valid = 1'b0;
   logic [CW-1:0] cc_count = '0;
   logic          cc_start, cc_stop, cc_reset, res_valid, busy;
   logic [CW-1:0] res_count;
   logic [1:0]    res_status;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int cnt;
      int st;
      int starts;
      int stops;
      int lat;
   } exp_t;

   exp_t sb[$];

   always #(PER/2) clk_CC = ~clk_CC;

   tdc_measure_sequencer #(
      .COUNT_W     (CW),
      .TIMEOUT_CYC (TMO),
      .VALID_WAIT  (VW)
   ) dut (
      .clk_CC     (clk_CC),
      .reset_CC   (reset_CC),
      .arm        (arm),
      .hit_start  (hit_start),
      .hit_stop   (hit_stop),
      .cc_valid   (cc_valid),
      .cc_count   (cc_count),
      .cc_start   (cc_start),
      .cc_stop    (cc_stop),
      .cc_reset   (cc_reset),
      .res_count  (res_count),
      .res_status (res_status),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .busy       (busy)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // CoarseCounter model: counts cycles from start pulse to stop pulse and
   // reports the count with valid one cycle after the stop pulse.
   bit drop_valid = 1'b0;
   int ctr        = 0;
   bit ctr_run    = 1'b0;
   bit pend       = 1'b0;

   always @(negedge clk_CC) begin
      cc_valid = 1'b0;
      cc_count = CW'($urandom);
      if (pend && !drop_valid) begin
         cc_valid = 1'b1;
         cc_count = CW'(ctr);
      end
      pend = 1'b0;
      if (cc_reset) ctr_run = 1'b0;
      if (cc_start) begin
         ctr     = 0;
         ctr_run = 1'b1;
      end else if (ctr_run) begin
         ctr++;
      end
      if (cc_stop) begin
         ctr_run = 1'b0;
         pend    = 1'b1;
      end
   end

   // Monitor
   int            cyc = 0, n_start = 0, n_stop = 0, stop_cyc = 0, rise_cyc = 0;
   logic          rv_prev = 1'b0;
   logic [CW-1:0] cap_cnt = '0;
   logic [1:0]    cap_st  = '0;
   exp_t          me;

   always @(negedge clk_CC) begin
      cyc++;
      if (!reset_CC) begin
         n_start = 0;
         n_stop  = 0;
         rv_prev = 1'b0;
      end else begin
         if (cc_start) n_start++;
         if (cc_stop) begin
            n_stop++;
            stop_cyc = cyc;
         end
         if (res_valid && !rv_prev) begin
            rise_cyc = cyc;
            cap_cnt  = res_count;
            cap_st   = res_status;
         end
         if (res_valid && res_ready) begin
            check("sb_has_entry", sb.size() > 0 ? 1 : 0, 1);
            if (sb.size() > 0) begin
               me = sb.pop_front();
               check("res_count", int'(res_count), me.cnt);
               check("res_status", int'(res_status), me.st);
               check("hold_count_stable", int'(res_count), int'(cap_cnt));
               check("hold_status_stable", int'(res_status), int'(cap_st));
               check("cc_start_pulses", n_start, me.starts);
               check("cc_stop_pulses", n_stop, me.stops);
               if (me.lat >= 0) check("stop_to_valid_latency", rise_cyc - stop_cyc, me.lat);
            end
            n_start = 0;
            n_stop  = 0;
         end
         rv_prev = res_valid;
      end
   end

   // Expected result from the measurement rules: forced stop TMO cycles after
   // start unless a stop edge arrives within TMO cycles; k=0 means no stop edge.
   function automatic exp_t model(input int kind, input int k, input bit drop);
      exp_t e;
      bit   timed_out;
      if (kind == K_COINC) begin
         e = '{cnt: 0, st: 2, starts: 0, stops: 0, lat: -1};
      end else begin
         timed_out = (k == 0) || (k > TMO);
         if (drop) e = '{cnt: 0, st: 3, starts: 1, stops: 1, lat: VW};
         else      e = '{cnt: timed_out ? TMO : k, st: timed_out ? 1 : 0, starts: 1, stops: 1, lat: 2};
      end
      return e;
   endfunction

   task automatic cyc_wait(input int n);
      repeat (n) begin
         @(posedge clk_CC);
         #2;
      end
   endtask

   task automatic pulse(input bit s, input bit p);
      hit_start = s;
      hit_stop  = p;
      cyc_wait(1);
      hit_start = 1'b0;
      hit_stop  = 1'b0;
   endtask

   task automatic accept();
      logic a;
      a = arm;
      res_ready = 1'b1;
      cyc_wait(1);
      res_ready = 1'b0;
      check("post_accept_busy", int'(busy), int'(a));
      check("post_accept_cc_reset", int'(cc_reset), 1);
      check("post_accept_res_valid", int'(res_valid), 0);
      cyc_wait(1);
      check("cc_reset_second_cycle", int'(cc_reset), int'(!a));
   endtask

   task automatic measure(input int kind, input int k, input bit drop, input bit arm_drop,
                          input int bp, input bit bp_hits);
      bit ok;
      drop_valid = drop;
      arm = 1'b1;
      cyc_wait(3);
      sb.push_back(model(kind, k, drop));
      if (kind == K_COINC) begin
         pulse(1'b1, 1'b1);
         if (arm_drop) arm = 1'b0;
      end else begin
         pulse(1'b1, 1'b0);
         if (arm_drop) arm = 1'b0;
         if (k > 0) begin
            cyc_wait(k - 1);
            pulse(1'b0, 1'b1);
         end
      end
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (res_valid) begin
            ok = 1'b1;
            break;
         end
         cyc_wait(1);
      end
      check("res_valid_arrives", int'(ok), 1);
      if (!ok) begin
         void'(sb.pop_front());
         return;
      end
      for (int i = 0; i < bp; i++) begin
         if (bp_hits) begin
            hit_start = i[0];
            hit_stop  = i[1];
         end
         cyc_wait(1);
      end
      hit_start = 1'b0;
      hit_stop  = 1'b0;
      cyc_wait(1);
      accept();
   endtask

   initial begin
      #(PER * 20000);
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset_CC  = 1'b0;
      arm       = 1'b0;
      hit_start = 1'b0;
      hit_stop  = 1'b0;
      res_ready = 1'b0;
      cyc_wait(3);
      check("rst_busy", int'(busy), 0);
      check("rst_cc_reset", int'(cc_reset), 1);
      check("rst_res_valid", int'(res_valid), 0);
      check("rst_cc_start", int'(cc_start), 0);
      check("rst_cc_stop", int'(cc_stop), 0);
      check("rst_res_count", int'(res_count), 0);
      check("rst_res_status", int'(res_status), 0);
      reset_CC = 1'b1;
      cyc_wait(2);
      check("idle_busy", int'(busy), 0);
      check("idle_cc_reset", int'(cc_reset), 1);

      measure(K_NORM, 5, 1'b0, 1'b0, 2, 1'b0);
      measure(K_NORM, 0, 1'b0, 1'b0, 0, 1'b0);
      measure(K_NORM, TMO, 1'b0, 1'b0, 0, 1'b0);
      measure(K_NORM, TMO + 1, 1'b0, 1'b0, 0, 1'b0);
      measure(K_COINC, 0, 1'b0, 1'b0, 1, 1'b0);
      measure(K_NORM, 5, 1'b1, 1'b0, 0, 1'b0);
      measure(K_NORM, 7, 1'b0, 1'b1, 20, 1'b1);

      // Reset in the middle of a measurement with hit_start held high.
      drop_valid = 1'b0;
      arm = 1'b1;
      cyc_wait(3);
      hit_start = 1'b1;
      cyc_wait(4);
      reset_CC = 1'b0;
      cyc_wait(1);
      reset_CC = 1'b1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_cc_reset", int'(cc_reset), 1);
      check("midrst_res_valid", int'(res_valid), 0);
      check("midrst_res_count", int'(res_count), 0);
      check("midrst_res_status", int'(res_status), 0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         cyc_wait(1);
         if (cc_start) n++;
      end
      check("no_start_from_held_level", n, 0);
      hit_start = 1'b0;
      cyc_wait(2);

      for (int it = 0; it < 30; it++) begin
         int kind, k;
         bit drop, ad;
         kind = ($urandom % 6 == 0) ? K_COINC : K_NORM;
         k    = ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, 22));
         drop = ($urandom % 4 == 0);
         ad   = ($urandom % 3 == 0);
         measure(kind, k, drop, ad, int'($urandom_range(0, 6)), bit'($urandom % 2));
      end

      cyc_wait(4);
      check("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
